// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, decode's hazard check and the
// register file write port. The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Handshake: a producer holds valid and its payload stable until it samples
    // ready high at a rising edge; valid && ready at that edge is one transfer.
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard1;
    logic            hazard2;
    logic            wEn;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] write_data;
    // Slot occupancy and age bit, exported for observation only.
    logic            dbg_alu_full;
    logic            dbg_lsu_full;
    logic            dbg_lsu_older;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output rs1, rs2,
        input  alu_ready, lsu_ready,
        input  hazard1, hazard2,
        input  wEn, rd, write_data,
        input  dbg_alu_full, dbg_lsu_full, dbg_lsu_older
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  rs1, rs2,
        output alu_ready, lsu_ready,
        output hazard1, hazard2,
        output wEn, rd, write_data,
        output dbg_alu_full, dbg_lsu_full, dbg_lsu_older
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first arbiter for the register file's single write port, with one
// holding slot per producer and RAW hazard reporting for pending writes.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    logic            alu_full;
    logic            lsu_full;
    logic            lsu_older;
    logic [AW-1:0]   alu_rd_q;
    logic [AW-1:0]   lsu_rd_q;
    logic [XLEN-1:0] alu_data_q;
    logic [XLEN-1:0] lsu_data_q;

    logic            alu_gnt;
    logic            lsu_gnt;
    logic            any_gnt;
    logic            alu_acc;
    logic            lsu_acc;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;

    logic            wen_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] wdata_q;

    // When both slots are full the age bit decides; otherwise the lone full slot wins.
    always_comb begin
        alu_gnt  = alu_full && (!lsu_full || !lsu_older);
        lsu_gnt  = lsu_full && (!alu_full || lsu_older);
        any_gnt  = alu_gnt || lsu_gnt;
        gnt_rd   = lsu_gnt ? lsu_rd_q   : alu_rd_q;
        gnt_data = lsu_gnt ? lsu_data_q : alu_data_q;
    end

    assign bus.alu_ready = !rst && (!alu_full || alu_gnt);
    assign bus.lsu_ready = !rst && (!lsu_full || lsu_gnt);
    assign alu_acc       = bus.alu_valid && bus.alu_ready;
    assign lsu_acc       = bus.lsu_valid && bus.lsu_ready;

    // Slot occupancy, age tracking and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_full  <= 1'b0;
            lsu_full  <= 1'b0;
            lsu_older <= 1'b0;
            wen_q     <= 1'b0;
            rd_q      <= '0;
            wdata_q   <= '0;
        end else begin
            if (alu_acc)
                alu_full <= 1'b1;
            else if (alu_gnt)
                alu_full <= 1'b0;

            if (lsu_acc)
                lsu_full <= 1'b1;
            else if (lsu_gnt)
                lsu_full <= 1'b0;

            // A fresh ALU load makes the LSU older, including a simultaneous
            // load of both; a lone LSU load makes the ALU older.
            if (alu_acc)
                lsu_older <= 1'b1;
            else if (lsu_acc)
                lsu_older <= 1'b0;

            // Writes to x0 retire the slot but never reach the register file.
            wen_q <= any_gnt && (gnt_rd != '0);
            if (any_gnt && (gnt_rd != '0)) begin
                rd_q    <= gnt_rd;
                wdata_q <= gnt_data;
            end
        end
    end

    // Payload is only meaningful while the slot is full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alu_acc) begin
            alu_rd_q   <= bus.alu_rd;
            alu_data_q <= bus.alu_data;
        end
        if (lsu_acc) begin
            lsu_rd_q   <= bus.lsu_rd;
            lsu_data_q <= bus.lsu_data;
        end
    end

    always_comb begin
        bus.hazard1 = (bus.rs1 != '0) &&
                      ((alu_full && (alu_rd_q == bus.rs1)) ||
                       (lsu_full && (lsu_rd_q == bus.rs1)) ||
                       (wen_q    && (rd_q     == bus.rs1)));
        bus.hazard2 = (bus.rs2 != '0) &&
                      ((alu_full && (alu_rd_q == bus.rs2)) ||
                       (lsu_full && (lsu_rd_q == bus.rs2)) ||
                       (wen_q    && (rd_q     == bus.rs2)));
    end

    assign bus.wEn           = wen_q;
    assign bus.rd            = rd_q;
    assign bus.write_data    = wdata_q;
    assign bus.dbg_alu_full  = alu_full;
    assign bus.dbg_lsu_full  = lsu_full;
    assign bus.dbg_lsu_older = lsu_older;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: cycle-exact checks of accept, grant,
// ordering, x0 handling, hazards, streaming throughput and mid-stream reset.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Write monitor: records each regfile write once per cycle, away from the edge
    logic [XLEN-1:0]    rf_model [32];
    logic [AW+XLEN-1:0] got_q[$];
    int                 got_cyc[$];
    logic [AW+XLEN-1:0] exp_q[$];
    logic               mon_en = 1'b0;
    int                 cyc    = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.wEn === 1'b1) begin
            rf_model[bus.rd] = bus.write_data;
            if (mon_en) begin
                got_q.push_back({bus.rd, bus.write_data});
                got_cyc.push_back(cyc);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = r;
        bus.alu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        bus.lsu_valid = v;
        bus.lsu_rd    = r;
        bus.lsu_data  = d;
    endtask

    task automatic idle();
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_alu(1'b1, 5'd9, 32'h99999999);
        drive_lsu(1'b0, '0, '0);
        bus.rs1 = 5'd9;
        bus.rs2 = 5'd9;
        repeat (2) tick();
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", bus.wEn); end
        total++; if (bus.rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", bus.rd); end
        total++; if (bus.write_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.write_data); end
        total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%b exp=0", bus.alu_ready); end
        total++; if (bus.lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready got=%b exp=0", bus.lsu_ready); end
        total++; if (bus.hazard1 !== 1'b0) begin bad++; $display("FAIL reset_hazard1 got=%b exp=0", bus.hazard1); end
        rst = 1'b0;
        idle();
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL release_alu_ready got=%b exp=1", bus.alu_ready); end
        total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL release_lsu_ready got=%b exp=1", bus.lsu_ready); end
        tick();
    endtask

    task automatic test_single_alu();
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd0;
        drive_alu(1'b1, 5'd5, 32'h55555555);
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", bus.alu_ready); end
        total++; if (bus.hazard1 !== 1'b0) begin bad++; $display("FAIL single_haz_pre got=%b exp=0", bus.hazard1); end
        tick();
        idle();
        #1;
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL single_wen_n got=%b exp=0", bus.wEn); end
        total++; if (bus.hazard1 !== 1'b1) begin bad++; $display("FAIL single_haz_n got=%b exp=1", bus.hazard1); end
        tick();
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd5, 32'h55555555})
            begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/55555555", bus.wEn, bus.rd, bus.write_data); end
        total++; if (bus.hazard1 !== 1'b1) begin bad++; $display("FAIL single_haz_n1 got=%b exp=1", bus.hazard1); end
        tick();
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL single_wen_n2 got=%b exp=0", bus.wEn); end
        total++; if (bus.hazard1 !== 1'b0) begin bad++; $display("FAIL single_haz_n2 got=%b exp=0", bus.hazard1); end
        total++; if (bus.write_data !== 32'h55555555) begin bad++; $display("FAIL single_hold got=%h exp=55555555", bus.write_data); end
    endtask

    task automatic test_simultaneous();
        bus.rs1 = 5'd4;
        bus.rs2 = 5'd3;
        drive_alu(1'b1, 5'd3, 32'h33333333);
        drive_lsu(1'b1, 5'd4, 32'h44444444);
        #1;
        total++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b11) begin bad++; $display("FAIL simul_ready_pre got=%b exp=11", {bus.alu_ready, bus.lsu_ready}); end
        tick();
        idle();
        #1;
        total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL simul_alu_ready_n got=%b exp=0", bus.alu_ready); end
        total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL simul_lsu_ready_n got=%b exp=1", bus.lsu_ready); end
        total++; if ({bus.hazard1, bus.hazard2} !== 2'b11) begin bad++; $display("FAIL simul_haz_n got=%b exp=11", {bus.hazard1, bus.hazard2}); end
        tick();
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd4, 32'h44444444})
            begin bad++; $display("FAIL simul_first got=%b/%0d/%h exp=1/4/44444444", bus.wEn, bus.rd, bus.write_data); end
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL simul_alu_ready_n1 got=%b exp=1", bus.alu_ready); end
        tick();
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd3, 32'h33333333})
            begin bad++; $display("FAIL simul_second got=%b/%0d/%h exp=1/3/33333333", bus.wEn, bus.rd, bus.write_data); end
        total++; if ({bus.hazard1, bus.hazard2} !== 2'b01) begin bad++; $display("FAIL simul_haz_n2 got=%b exp=01", {bus.hazard1, bus.hazard2}); end
        tick();
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL simul_wen_n3 got=%b exp=0", bus.wEn); end
        total++; if (bus.hazard2 !== 1'b0) begin bad++; $display("FAIL simul_haz2_n3 got=%b exp=0", bus.hazard2); end
    endtask

    task automatic test_same_rd();
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd0;
        drive_lsu(1'b1, 5'd7, 32'hAAAAAAAA);
        tick();
        idle();
        drive_alu(1'b1, 5'd7, 32'hBBBBBBBB);
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL samerd_alu_ready got=%b exp=1", bus.alu_ready); end
        tick();
        idle();
        #1;
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd7, 32'hAAAAAAAA})
            begin bad++; $display("FAIL samerd_first got=%b/%0d/%h exp=1/7/aaaaaaaa", bus.wEn, bus.rd, bus.write_data); end
        total++; if (bus.hazard1 !== 1'b1) begin bad++; $display("FAIL samerd_haz got=%b exp=1", bus.hazard1); end
        tick();
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd7, 32'hBBBBBBBB})
            begin bad++; $display("FAIL samerd_second got=%b/%0d/%h exp=1/7/bbbbbbbb", bus.wEn, bus.rd, bus.write_data); end
        tick();
        total++; if (rf_model[7] !== 32'hBBBBBBBB) begin bad++; $display("FAIL samerd_final_x7 got=%h exp=bbbbbbbb", rf_model[7]); end
        total++; if (bus.hazard1 !== 1'b0) begin bad++; $display("FAIL samerd_haz_end got=%b exp=0", bus.hazard1); end
    endtask

    task automatic test_x0();
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd1;
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL x0_ready_pre got=%b exp=1", bus.alu_ready); end
        tick();
        drive_alu(1'b1, 5'd1, 32'h01010101);
        #1;
        total++; if (bus.hazard1 !== 1'b0) begin bad++; $display("FAIL x0_hazard1 got=%b exp=0", bus.hazard1); end
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL x0_ready_n got=%b exp=1", bus.alu_ready); end
        total++; if (bus.hazard2 !== 1'b0) begin bad++; $display("FAIL x0_hazard2_pre got=%b exp=0", bus.hazard2); end
        tick();
        idle();
        #1;
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", bus.wEn); end
        total++; if (bus.hazard2 !== 1'b1) begin bad++; $display("FAIL x0_hazard2_n1 got=%b exp=1", bus.hazard2); end
        tick();
        total++; if ({bus.wEn, bus.rd, bus.write_data} !== {1'b1, 5'd1, 32'h01010101})
            begin bad++; $display("FAIL x0_next_write got=%b/%0d/%h exp=1/1/01010101", bus.wEn, bus.rd, bus.write_data); end
        tick();
    endtask

    task automatic test_streaming();
        int   ai;
        int   li;
        int   n;
        logic acc_a;
        logic acc_l;
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        for (int i = 1; i <= 31; i++) begin
            exp_q.push_back({5'(i), ~(32'(i) * 32'h11111111)});
            exp_q.push_back({5'(i), 32'(i) * 32'h11111111});
        end
        ai = 1;
        li = 1;
        mon_en = 1'b1;
        for (int c = 0; c < 200 && (ai <= 31 || li <= 31); c++) begin
            drive_alu(ai <= 31, 5'(ai), 32'(ai) * 32'h11111111);
            drive_lsu(li <= 31, 5'(li), ~(32'(li) * 32'h11111111));
            #1;
            acc_a = bus.alu_valid && bus.alu_ready;
            acc_l = bus.lsu_valid && bus.lsu_ready;
            tick();
            if (acc_a) ai++;
            if (acc_l) li++;
        end
        idle();
        repeat (4) tick();
        mon_en = 1'b0;
        total++; if (ai != 32 || li != 32) begin bad++; $display("FAIL stream_budget got=%0d/%0d exp=32/32", ai, li); end
        total++; if (got_q.size() != 62) begin bad++; $display("FAIL stream_count got=%0d exp=62", got_q.size()); end
        n = (got_q.size() < 62) ? got_q.size() : 62;
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stream_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        if (n > 1) begin
            total++;
            if (got_cyc[n-1] - got_cyc[0] != n - 1) begin
                bad++;
                $display("FAIL stream_gapless got=%0d exp=%0d", got_cyc[n-1] - got_cyc[0], n - 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) begin
            drive_alu(1'b1, 5'(i + 10), 32'(i) * 32'h01020304);
            drive_lsu(1'b1, 5'(i + 20), 32'(i) * 32'h0A0B0C0D);
            tick();
        end
        rst = 1'b1;
        idle();
        tick();
        got_q.delete();
        got_cyc.delete();
        mon_en = 1'b1;
        total++; if (bus.wEn !== 1'b0) begin bad++; $display("FAIL midrst_wen got=%b exp=0", bus.wEn); end
        total++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b00) begin bad++; $display("FAIL midrst_ready got=%b exp=00", {bus.alu_ready, bus.lsu_ready}); end
        rst = 1'b0;
        bus.rs1 = 5'd14;
        bus.rs2 = 5'd24;
        #1;
        total++; if ({bus.hazard1, bus.hazard2} !== 2'b00) begin bad++; $display("FAIL midrst_hazard got=%b exp=00", {bus.hazard1, bus.hazard2}); end
        total++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b11) begin bad++; $display("FAIL midrst_ready_after got=%b exp=11", {bus.alu_ready, bus.lsu_ready}); end
        repeat (5) tick();
        mon_en = 1'b0;
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale_writes got=%0d exp=0", got_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rs1 = '0;
        bus.rs2 = '0;
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_same_rd();
        test_x0();
        test_streaming();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It accepts result writes from two producers, the ALU and the load/store unit, through valid/ready handshakes and holds each in a one-entry slot. It grants the port oldest-first and drives the regfile `wEn`/`rd`/`write_data` inputs from registers. It also reports RAW hazards for pending writes, so decode can stall reads that would see stale data.

## Interface
- `XLEN`, 32, data width of the register file
- `AW`, 5, register address width (32 registers, x0 hard-wired zero)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU write request
- `alu_ready`  out  1  ALU slot can accept
- `alu_rd`  in  AW  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  LSU write request
- `lsu_ready`  out  1  LSU slot can accept
- `lsu_rd`  in  AW  LSU destination register
- `lsu_data`  in  XLEN  LSU load data
- `rs1`, `rs2`  in  AW each  decode-stage read addresses to check
- `hazard1`, `hazard2`  out  1 each  pending write targets `rs1` / `rs2`
- `wEn`  out  1  regfile write enable (registered)
- `rd`  out  AW  regfile write address (registered)
- `write_data`  out  XLEN  regfile write data (registered)

## Operation
- State per source: one slot {full, rd, data, age}; one global "LSU older" bit resolved from age.
- Accept:
  - `src_ready` = !rst && (!slot_full || slot granted this cycle).
  - On `valid && ready` at an edge, the slot loads {rd, data}, sets full, and is stamped younger than the other slot if that slot is full.
- Grant, evaluated each cycle over the full slots:
  - Exactly one full: grant it.
  - Both full: grant the older.
  - Both loaded on the same edge: LSU is older.
  - Granted slot clears at the edge unless it reloads the same edge.
  - Reload on the edge the slot is granted (back-to-back) is legal and gives full throughput of one write per cycle per source, alternating when both stream.
- Output register, at each edge:
  - Grant with slot rd != 0: `wEn`<=1, `rd`<=slot rd, `write_data`<=slot data.
  - Grant with slot rd == 0: `wEn`<=0 (write silently dropped; slot still retires).
  - No grant: `wEn`<=0; `rd`/`write_data` hold their last value.
- Ordering: two pending writes to the same rd retire in acceptance order, so the younger value lands last.
- Hazard, combinational:
  - `hazardN` = (`rsN` != 0) && (ALU slot full with rd==rsN || LSU slot full with rd==rsN || `wEn` && `rd`==rsN).
  - Requests presented in the same cycle are not counted until accepted.
- Starvation: impossible; any full slot is granted within 2 cycles.

## Timing
- Reset values:
  - Both slots empty.
  - `wEn`=0, `rd`=0, `write_data`=0.
  - `alu_ready`=`lsu_ready`=0 while `rst`=1; both ready are 1 in the first cycle after `rst` falls.
  - `hazard1`=`hazard2`=0.
- Latency, single request:
  - Accepted at edge N.
  - Granted during cycle N..N+1; `wEn`=1 from edge N+1.
  - Regfile stores it at edge N+2.
  - `hazard` is high from edge N until edge N+2.
- Both sources accepted at edge N: LSU writes (`wEn` from N+1), ALU writes (`wEn` from N+2); `alu_ready`=0 during cycle N..N+1.
- `rst` asserted mid-operation: at the next edge all slots are discarded, `wEn`<=0, and no pending write reaches the regfile; in-flight data is lost by design.
- `valid` held with `ready`=0: request and payload must stay stable; nothing is sampled.

## Test plan
- Reset: `rst`=1 for 2 cycles with `alu_valid`=1 -> `wEn`=0, `rd`=0, `write_data`=0, both ready 0; first cycle after release both ready 1.
- Single ALU write: `alu_rd`=5, `alu_data`=32'h55555555 accepted at edge N -> `wEn`=1, `rd`=5, `write_data`=32'h55555555 in cycle after N+1; `hazard1`=1 for `rs1`=5 over cycles N..N+2, then 0.
- Simultaneous: ALU {3, 32'h33333333} and LSU {4, 32'h44444444} at edge N -> write rd=4 at N+1, rd=3 at N+2; `alu_ready`=0 for exactly one cycle.
- Same-rd ordering: LSU {7, 32'hAAAAAAAA} accepted at N, ALU {7, 32'hBBBBBBBB} accepted at N+1 while LSU still pending -> writes in order AAAAAAAA then BBBBBBBB; final x7 = 32'hBBBBBBBB.
- x0: ALU {0, 32'hFFFFFFFF} -> `wEn` never asserts, slot retires, `hazard1`=0 for `rs1`=0, `alu_ready` stays 1.
- Streaming: both sources valid every cycle for 31 writes each (`rd`=i, data=i*32'h11111111) -> alternating LSU/ALU grants, one `wEn` per cycle, no lost or duplicated write; `rst` pulsed mid-stream -> `wEn`=0 next cycle and no stale write afterward.
